// File: rtl/test_status_monitor.sv
// Test status monitor: watches per-channel tohost CSR words, a cycle budget and memory traffic,
// and latches a sticky pass/fail verdict. Optional memory request counters are enabled with MEM_STATS_EN.
module test_status_monitor #(
  parameter int NUM_CH = 4,
  parameter int CSR_W  = 32,
  parameter int CNT_W  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         max_cycles,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*CSR_W-1:0]  csr,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  input  logic                     mem_req_rw,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_reason,
  output logic [3:0]               fail_ch,
  output logic [CSR_W-1:0]         fail_code,
  output logic [NUM_CH-1:0]        pass_mask,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [31:0]              mem_rd_count,
  output logic [31:0]              mem_wr_count
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSN_NONE    = 2'b00,
    RSN_TOHOST  = 2'b01,
    RSN_TIMEOUT = 2'b10
  } reason_t;

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   ch_pass_now;
  logic [NUM_CH-1:0]   ch_fail_now;
  logic                tohost_fail;
  logic                timeout;
  logic                all_passed;
  logic [3:0]          fail_idx;
  logic [CSR_W-1:0]    fail_word;
  logic [1:0]          reason_nxt;
  logic [3:0]          fail_ch_nxt;
  logic [CSR_W-1:0]    fail_code_nxt;
  logic                running;

  assign running = (state == ST_RUN);

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    ch_pass_now = '0;
    ch_fail_now = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_pass_now[i] = ch_en[i] && (csr[i*CSR_W +: CSR_W] == CSR_W'(1));
      ch_fail_now[i] = ch_en[i] && !pass_mask[i] &&
                       (csr[i*CSR_W +: CSR_W] > CSR_W'(1)) &&
                       (cycle_count > CNT_W'(1));
    end
  end

  // Scan from the top down so the lowest failing channel is the one left captured.
  always_comb begin
    fail_idx  = '0;
    fail_word = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_fail_now[i]) begin
        fail_idx  = 4'(i);
        fail_word = csr[i*CSR_W +: CSR_W];
      end
    end
  end

  assign tohost_fail = |ch_fail_now;
  assign timeout     = (max_cycles != '0) && (cycle_count > max_cycles);
  assign all_passed  = &(pass_mask | ch_pass_now | ~ch_en);

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next-state logic: tohost failure beats timeout, which beats pass.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (tohost_fail || timeout) state_nxt = ST_FAIL;
        else if (all_passed)        state_nxt = ST_PASS;
      end
      ST_PASS: state_nxt = ST_PASS;
      ST_FAIL: state_nxt = ST_FAIL;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Output logic: failure capture values for the registered outputs.
  always_comb begin
    reason_nxt    = fail_reason;
    fail_ch_nxt   = fail_ch;
    fail_code_nxt = fail_code;
    if (running) begin
      if (tohost_fail) begin
        reason_nxt    = RSN_TOHOST;
        fail_ch_nxt   = fail_idx;
        fail_code_nxt = fail_word;
      end else if (timeout) begin
        reason_nxt    = RSN_TIMEOUT;
        fail_ch_nxt   = '0;
        fail_code_nxt = '0;
      end else begin
        reason_nxt    = RSN_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_reason <= RSN_NONE;
      fail_ch     <= '0;
      fail_code   <= '0;
    end else begin
      done        <= (state_nxt != ST_RUN);
      pass        <= (state_nxt == ST_PASS);
      fail        <= (state_nxt == ST_FAIL);
      fail_reason <= reason_nxt;
      fail_ch     <= fail_ch_nxt;
      fail_code   <= fail_code_nxt;
    end
  end

  // The cycle counter stops on the deciding cycle so it reports the value that triggered the verdict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
      pass_mask   <= '0;
    end else if (running) begin
      pass_mask <= pass_mask | ch_pass_now;
      if (state_nxt == ST_RUN && cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
    end
  end

`ifdef MEM_STATS_EN
  logic mem_fire;
  assign mem_fire = mem_req_valid && mem_req_ready && running;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_rd_count <= '0;
      mem_wr_count <= '0;
    end else if (mem_fire) begin
      if (mem_req_rw) begin
        if (mem_wr_count != 32'hFFFF_FFFF) mem_wr_count <= mem_wr_count + 32'd1;
      end else begin
        if (mem_rd_count != 32'hFFFF_FFFF) mem_rd_count <= mem_rd_count + 32'd1;
      end
    end
  end
`else
  logic unused_mem;
  assign unused_mem   = &{1'b0, mem_req_valid, mem_req_ready, mem_req_rw};
  assign mem_rd_count = '0;
  assign mem_wr_count = '0;
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// Scoreboard bench for test_status_monitor: directed scenarios plus randomized runs against a
// cycle-level behavioural model; honours MEM_STATS_EN when the design is built with it.
module tb_test_status_monitor;

  localparam int NUM_CH = 4;
  localparam int CSR_W  = 32;
  localparam int CNT_W  = 64;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [CNT_W-1:0]        max_cycles;
  logic [NUM_CH-1:0]       ch_en;
  logic [CSR_W-1:0]        tb_csr [NUM_CH];
  logic [NUM_CH*CSR_W-1:0] csr;
  logic                    mem_req_valid, mem_req_ready, mem_req_rw;
  logic                    done, pass, fail;
  logic [1:0]              fail_reason;
  logic [3:0]              fail_ch;
  logic [CSR_W-1:0]        fail_code;
  logic [NUM_CH-1:0]       pass_mask;
  logic [CNT_W-1:0]        cycle_count;
  logic [31:0]             mem_rd_count, mem_wr_count;

  assign csr = {tb_csr[3], tb_csr[2], tb_csr[1], tb_csr[0]};

  always #5 clk = ~clk;

  test_status_monitor #(.NUM_CH(NUM_CH), .CSR_W(CSR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .max_cycles(max_cycles), .ch_en(ch_en), .csr(csr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .done(done), .pass(pass), .fail(fail), .fail_reason(fail_reason), .fail_ch(fail_ch),
    .fail_code(fail_code), .pass_mask(pass_mask), .cycle_count(cycle_count),
    .mem_rd_count(mem_rd_count), .mem_wr_count(mem_wr_count)
  );

  typedef struct {
    logic        done, pass, fail;
    logic [1:0]  reason;
    logic [3:0]  ch;
    logic [31:0] code;
    logic [3:0]  pmask;
    logic [63:0] cyc;
    logic [31:0] rd, wr;
  } obs_t;

  obs_t cur;
  obs_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the visible outputs must be after the coming clock edge.
  function automatic obs_t model_next(input obs_t m);
    obs_t n;
    int   hit;
    bit   tmo, all;
    n   = m;
    hit = -1;
    if (!reset) begin
      n = '{default: '0};
      return n;
    end
    if (m.done) return m;
    for (int i = 0; i < NUM_CH; i++)
      if (hit < 0 && ch_en[i] && !m.pmask[i] && tb_csr[i] > 1 && m.cyc > 1) hit = i;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_en[i] && tb_csr[i] == 1) n.pmask[i] = 1'b1;
    tmo = (max_cycles != 0) && (m.cyc > max_cycles);
    all = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_en[i] && !n.pmask[i]) all = 1'b0;
    if (hit >= 0) begin
      n.fail = 1'b1; n.reason = 2'b01; n.ch = 4'(hit); n.code = tb_csr[hit];
    end else if (tmo) begin
      n.fail = 1'b1; n.reason = 2'b10; n.ch = 4'd0; n.code = 32'd0;
    end else if (all) begin
      n.pass = 1'b1;
    end else if (m.cyc != 64'hFFFF_FFFF_FFFF_FFFF) begin
      n.cyc = m.cyc + 64'd1;
    end
    n.done = n.pass | n.fail;
`ifdef MEM_STATS_EN
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_rw) begin
        if (m.wr != 32'hFFFF_FFFF) n.wr = m.wr + 32'd1;
      end else begin
        if (m.rd != 32'hFFFF_FFFF) n.rd = m.rd + 32'd1;
      end
    end
`endif
    return n;
  endfunction

  // One clock: predict, let the edge happen, then queue the prediction for the monitor.
  task automatic tick();
    obs_t nxt;
    nxt = model_next(cur);
    @(posedge clk);
    #1;
    exp_q.push_back(nxt);
    cur = nxt;
  endtask

  task automatic set_idle();
    for (int i = 0; i < NUM_CH; i++) tb_csr[i] = '0;
    mem_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_req_rw    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic mem_op(input logic v, input logic r, input logic rw);
    mem_req_valid = v;
    mem_req_ready = r;
    mem_req_rw    = rw;
    tick();
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("done",        64'(done),         64'(e.done));
      check("pass",        64'(pass),         64'(e.pass));
      check("fail",        64'(fail),         64'(e.fail));
      check("fail_reason", 64'(fail_reason),  64'(e.reason));
      check("fail_ch",     64'(fail_ch),      64'(e.ch));
      check("fail_code",   64'(fail_code),    64'(e.code));
      check("pass_mask",   64'(pass_mask),    64'(e.pmask));
      check("cycle_count", cycle_count,       e.cyc);
      check("mem_rd",      64'(mem_rd_count), 64'(e.rd));
      check("mem_wr",      64'(mem_wr_count), 64'(e.wr));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    int          len;
    cur        = '{default: '0};
    reset      = 1'b0;
    max_cycles = '0;
    ch_en      = 4'hF;
    set_idle();

    // Reset state, then channels pass one by one; verdict one cycle after the last.
    do_reset();
    check("reset_done", 64'(done), 64'd0);
    for (int k = 0; k <= 45; k++) begin
      for (int c = 0; c < NUM_CH; c++) tb_csr[c] = (k >= 10 * (c + 1)) ? 32'd1 : 32'd0;
      tick();
      if (k == 39) check("seq_pass_early", 64'(pass), 64'd0);
      if (k == 40) begin
        check("seq_pass", 64'(pass), 64'd1);
        check("seq_done", 64'(done), 64'd1);
        check("seq_fail", 64'(fail), 64'd0);
      end
    end

    // tohost failure on ch2 while ch0 reports success in the same cycle.
    set_idle();
    do_reset();
    for (int k = 0; k < 15; k++) tick();
    tb_csr[2] = 32'd7;
    tb_csr[0] = 32'd1;
    tick();
    check("th_fail",   64'(fail),        64'd1);
    check("th_reason", 64'(fail_reason), 64'd1);
    check("th_ch",     64'(fail_ch),     64'd2);
    check("th_code",   64'(fail_code),   64'd7);
    check("th_pass",   64'(pass),        64'd0);
    tb_csr[1] = 32'd3;
    tick();
    check("th_sticky_ch", 64'(fail_ch), 64'd2);

    // Timeout with max_cycles = 50.
    set_idle();
    do_reset();
    max_cycles = 64'd50;
    for (int k = 0; k < 60; k++) tick();
    check("to_fail",   64'(fail),        64'd1);
    check("to_reason", 64'(fail_reason), 64'd2);
    check("to_count",  cycle_count,      64'd51);
    check("to_code",   64'(fail_code),   64'd0);

    // One reset cycle while in FAIL clears everything; counting restarts.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_fail",  64'(fail),        64'd0);
    check("rst_count", cycle_count,      64'd0);
    for (int k = 0; k < 3; k++) tick();
    check("rst_recount", cycle_count, 64'd3);

    // Two channels failing together while the timeout also holds.
    set_idle();
    max_cycles = 64'd5;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    tb_csr[1] = 32'd5;
    tb_csr[3] = 32'd9;
    tick();
    check("pri_reason", 64'(fail_reason), 64'd1);
    check("pri_ch",     64'(fail_ch),     64'd1);
    check("pri_code",   64'(fail_code),   64'd5);

    // Memory request accounting.
    set_idle();
    max_cycles = '0;
    do_reset();
    mem_op(1'b1, 1'b1, 1'b0);
    mem_op(1'b1, 1'b1, 1'b1);
    mem_op(1'b1, 1'b1, 1'b0);
    mem_op(1'b1, 1'b0, 1'b1);
    mem_op(1'b1, 1'b1, 1'b1);
    mem_op(1'b1, 1'b1, 1'b0);
    mem_op(1'b0, 1'b1, 1'b0);
`ifdef MEM_STATS_EN
    check("mem_rd_total", 64'(mem_rd_count), 64'd3);
    check("mem_wr_total", 64'(mem_wr_count), 64'd2);
`else
    check("mem_rd_total", 64'(mem_rd_count), 64'd0);
    check("mem_wr_total", 64'(mem_wr_count), 64'd0);
`endif

    // No channels enabled: pass on the first running cycle.
    set_idle();
    ch_en = 4'h0;
    do_reset();
    tick();
    check("noen_pass",  64'(pass),   64'd1);
    check("noen_count", cycle_count, 64'd0);

    // Randomized runs.
    for (int run = 0; run < 25; run++) begin
      set_idle();
      ch_en      = 4'($urandom_range(0, 15));
      max_cycles = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(3, 40));
      do_reset();
      len = $urandom_range(10, 60);
      for (int k = 0; k < len; k++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r = $urandom_range(0, 39);
          if (r < 30)      tb_csr[c] = 32'd0;
          else if (r < 37) tb_csr[c] = 32'd1;
          else             tb_csr[c] = 32'($urandom_range(2, 300));
        end
        mem_req_valid = 1'($urandom_range(0, 1));
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_req_rw    = 1'($urandom_range(0, 1));
        reset         = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
        tick();
      end
      reset = 1'b1;
    end

    @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_status_monitor.md
TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent tohost/CSR channels (1..16).
REQ-002 Parameter CSR_W, default 32, width of each channel's CSR word.
REQ-003 Parameter CNT_W, default 64, width of cycle counter and max_cycles.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 max_cycles  input  CNT_W  timeout limit; 0 disables timeout.
REQ-007 ch_en  input  NUM_CH  per-channel enable; disabled channel counts as passed.
REQ-008 csr  input  NUM_CH*CSR_W  packed tohost words; channel i at bits [i*CSR_W +: CSR_W].
REQ-009 mem_req_valid  input  1  memory request valid, observed only.
REQ-010 mem_req_ready  input  1  memory request ready, observed only.
REQ-011 mem_req_rw  input  1  1 = write, 0 = read.
REQ-012 done  output  1  test finished (pass or fail), sticky.
REQ-013 pass  output  1  test passed, sticky.
REQ-014 fail  output  1  test failed, sticky.
REQ-015 fail_reason  output  2  00 none, 01 tohost code, 10 timeout.
REQ-016 fail_ch  output  4  channel index of the captured tohost failure.
REQ-017 fail_code  output  CSR_W  captured CSR value of the failing channel.
REQ-018 pass_mask  output  NUM_CH  per-channel sticky pass flags.
REQ-019 cycle_count  output  CNT_W  cycles spent in RUN.
REQ-020 mem_rd_count, mem_wr_count  output  32 each  accepted read/write request counts.

Function
REQ-021 FSM states RUN, PASS, FAIL; RUN entered from reset; PASS and FAIL terminal until reset.
REQ-022 In RUN, cycle_count increments by 1 per cycle and saturates at all-ones; frozen in PASS/FAIL.
REQ-023 Channel i passes when ch_en[i]=1, csr_i==1 and the channel has not failed; pass_mask[i] set next cycle and sticky.
REQ-024 Channel i fails when ch_en[i]=1, pass_mask[i]=0, csr_i>1 and cycle_count>1.
REQ-025 Once pass_mask[i] is set, later csr_i values are ignored.
REQ-026 Timeout fails when max_cycles!=0 and cycle_count>max_cycles.
REQ-027 Priority in one cycle: tohost fail > timeout > pass; among multiple failing channels, lowest index captured.
REQ-028 On tohost fail: FAIL, fail_reason=01, fail_ch and fail_code captured from that cycle's inputs.
REQ-029 On timeout: FAIL, fail_reason=10, fail_ch=0, fail_code=0.
REQ-030 PASS entered when (pass_mask | this-cycle passes | ~ch_en) is all ones and no fail condition holds.
REQ-031 ch_en all zero -> PASS on first RUN cycle.
REQ-032 All outputs registered; done/pass/fail rise exactly 1 cycle after the deciding sample; done = pass|fail; pass and fail never both 1.

Reset
REQ-033 reset=0 at a rising edge forces RUN, all outputs 0, pass_mask 0, counters 0, regardless of current state.
REQ-034 Reset mid-test discards captured failure information; counting restarts from 0 on the first cycle with reset=1.

Configuration
REQ-035 Macro MEM_STATS_EN defined: in RUN, mem_rd_count/mem_wr_count increment on mem_req_valid&&mem_req_ready with mem_req_rw=0/1; saturate at 32'hFFFFFFFF; frozen in PASS/FAIL.
REQ-036 MEM_STATS_EN undefined: no counter logic; mem_rd_count and mem_wr_count tied to 0; mem_* inputs unused.

Verification
REQ-037 NUM_CH=4, ch_en=4'hF, csr channels set to 1 at cycles 10,20,30,40 -> pass_mask fills, pass=done=1 at cycle 41, fail=0.
REQ-038 ch2 csr=7 at cycle 15, ch0 csr=1 same cycle -> fail=1, fail_reason=01, fail_ch=2, fail_code=7, pass=0.
REQ-039 max_cycles=50, csr all 0 -> fail with fail_reason=10 one cycle after cycle_count reaches 51; cycle_count holds 51.
REQ-040 ch1 and ch3 csr=5 and 9 same cycle, with timeout also true -> fail_reason=01, fail_ch=1, fail_code=5.
REQ-041 Reset asserted for 1 cycle while in FAIL -> all outputs 0 next cycle, counting resumes from 0.
REQ-042 MEM_STATS_EN: 3 handshaked reads, 2 writes, 1 valid-without-ready -> mem_rd_count=3, mem_wr_count=2; without macro both 0.
